// File: rtl/pipelined_instruction_memory.sv
// Word-addressed instruction store between the fetch stage and the IF/ID register.
// After reset the block is in LOAD mode, where a boot loader fills the array and
// reads are suppressed. LoadDone switches it to RUN mode. In RUN mode the array is
// write-protected and serves one registered fetch per cycle, with stall and flush
// control on the output register.
module pipelined_instruction_memory #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read_en,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_done,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic                    valid,
  output logic [1:0]              fault,
  output logic                    running,
  output logic [$clog2(DEPTH):0]  load_count,
  output logic                    load_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  // One past the last valid byte address; anything at or above it is out of range.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH) << 2;
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEPTH);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_reg;

  // Storage starts out as all bubbles; reset deliberately leaves it untouched so
  // a program survives a reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [DATA_WIDTH-1:0] instruction_reg;
  logic                  valid_reg;
  logic [1:0]            fault_reg;
  logic [CNT_W-1:0]      load_count_reg;
  logic                  load_err_reg;

  // Address decode for the fetch and loader ports. Byte-offset bits never index.
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_oor;
  logic             fetch_mis;
  logic [IDX_W-1:0] load_idx;
  logic             load_oor;
  logic             load_mis;
  logic             load_write;
  logic             load_reject;
  logic             run_mode;

  always_comb begin
    fetch_idx   = address[IDX_W+1:2];
    fetch_oor   = ({1'b0, address} >= MEM_BYTES);
    fetch_mis   = |address[1:0];
    load_idx    = load_addr[IDX_W+1:2];
    load_oor    = ({1'b0, load_addr} >= MEM_BYTES);
    load_mis    = |load_addr[1:0];
    run_mode    = (state_reg == ST_RUN);
    // A loader write lands only in LOAD mode at an aligned, in-range word.
    load_write  = !reset && load_en && !run_mode && !load_mis && !load_oor;
    // Everything else the loader attempts is refused and flagged.
    load_reject = load_en && (run_mode || load_mis || load_oor);
  end

  // Array write port, used only by the boot loader.
  always_ff @(posedge clk) begin
    if (load_write) begin
      mem[load_idx] <= load_data;
    end
  end

  // Registered read port: flush beats stall, stall holds, out-of-range reads a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_reg <= NOP_WORD;
    end else if (!run_mode || flush) begin
      instruction_reg <= NOP_WORD;
    end else if (stall) begin
      instruction_reg <= instruction_reg;
    end else if (read_en && !fetch_oor) begin
      instruction_reg <= mem[fetch_idx];
    end else begin
      instruction_reg <= NOP_WORD;
    end
  end

  // Valid and fault qualifiers follow the same priority as the data register.
  always_ff @(posedge clk) begin
    if (reset || !run_mode || flush) begin
      valid_reg <= 1'b0;
      fault_reg <= 2'b00;
    end else if (stall) begin
      valid_reg <= valid_reg;
      fault_reg <= fault_reg;
    end else if (read_en) begin
      valid_reg <= 1'b1;
      fault_reg <= {fetch_oor, fetch_mis};
    end else begin
      valid_reg <= 1'b0;
      fault_reg <= 2'b00;
    end
  end

  // Mode FSM: LoadDone moves LOAD to RUN; only reset returns to LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_LOAD;
    end else begin
      case (state_reg)
        ST_LOAD: if (load_done) state_reg <= ST_RUN;
        ST_RUN:  state_reg <= ST_RUN;
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  // Loader bookkeeping: saturating accepted-write count and sticky rejection flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count_reg <= '0;
      load_err_reg   <= 1'b0;
    end else begin
      if (load_write && (load_count_reg != CNT_MAX)) begin
        load_count_reg <= load_count_reg + 1'b1;
      end
      if (load_reject) begin
        load_err_reg <= 1'b1;
      end
    end
  end

  assign instruction = instruction_reg;
  assign valid       = valid_reg;
  assign fault       = fault_reg;
  assign running     = (state_reg == ST_RUN);
  assign load_count  = load_count_reg;
  assign load_err    = load_err_reg;

endmodule

// File: doc/pipelined_instruction_memory.md
Name: pipelined_instruction_memory

Overview:
- Parametrised, word-addressed instruction store with registered (1-cycle) read, stall/flush control and a boot-load write port.
- Sits between the PC/fetch stage and the IF/ID pipeline register.
- After reset it is in LOAD mode, where a loader writes the program into it. It then switches to RUN mode, where it is read-only and serves fetches.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
DEPTH, 128, number of words (power of two, at least 4)
ADDR_WIDTH, 32, byte-address width
NOP_WORD, 32'h00000000, fill/bubble value (sll $0,$0,0)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
Address  input  ADDR_WIDTH  fetch byte address
ReadEn  input  1  fetch request
Stall  input  1  hold the output register
Flush  input  1  insert a bubble
LoadEn  input  1  loader write strobe
LoadAddr  input  ADDR_WIDTH  loader byte address
LoadData  input  DATA_WIDTH  loader write word
LoadDone  input  1  end-of-load pulse; enter RUN
Instruction  output  DATA_WIDTH  registered fetched word
Valid  output  1  Instruction holds a real fetch
Fault  output  2  bit0 = misaligned fetch, bit1 = out-of-range fetch
Running  output  1  1 in RUN, 0 in LOAD
LoadCount  output  clog2(DEPTH)+1  accepted load writes, saturates at DEPTH
LoadErr  output  1  sticky rejected-write flag

Behaviour:
- Index: IDX_W = clog2(DEPTH); word index = Address[IDX_W+1:2]. Address bits [1:0] are never used for indexing.
- Out-of-range: any address >= DEPTH*4.
- Memory contents at time zero are NOP_WORD in every word. Reset does NOT clear memory.
- Reset (sync, highest priority):
  - state = LOAD
  - Instruction = NOP_WORD, Valid = 0, Fault = 0
  - Running = 0, LoadCount = 0, LoadErr = 0
  - Reset mid-load: words already written are kept; the counter is zeroed.
- FSM: LOAD -> RUN on LoadDone=1. RUN -> LOAD only on Reset. LoadDone in RUN is ignored.
- LOAD mode:
  - ReadEn is ignored; Valid stays 0 and Instruction stays NOP_WORD.
  - LoadEn=1 with an aligned, in-range LoadAddr: write at the edge; LoadCount increments, saturating at DEPTH.
  - LoadEn=1 with a misaligned or out-of-range LoadAddr: no write; LoadErr sets to 1.
  - LoadEn and LoadDone in the same cycle: the write completes, then RUN is entered. Running=1 from the next cycle.
- RUN mode: memory is write-protected. LoadEn=1 causes no write and sets LoadErr=1.
- RUN read priority at each edge, highest first:
  - Flush: Instruction = NOP_WORD, Valid = 0, Fault = 0. Flush overrides Stall.
  - Stall: Instruction, Valid and Fault all hold.
  - ReadEn: Valid = 1. Fault[0] = |Address[1:0]; Fault[1] = out-of-range. Instruction = NOP_WORD if out-of-range, else Memory[index]. A misaligned fetch still returns the truncated-word contents.
  - Otherwise: Instruction = NOP_WORD, Valid = 0, Fault = 0.
- Latency: exactly 1 cycle from the Address/ReadEn sample to Instruction.
- Throughput: one fetch per cycle. Back-to-back addresses produce back-to-back outputs.
- Combinational read-during-write is impossible because the two modes are exclusive.

Test Plan:
- Reset, then load 0x0..0xC with words 0x20100001, 0x20110001, 0x02118024, 0x0200802A, then LoadDone -> Running=1 next cycle, LoadCount=4, LoadErr=0.
- RUN, ReadEn=1, Address 0x0, 0x4, 0x8 on consecutive cycles -> Instruction = 0x20100001, 0x20110001, 0x02118024 one cycle later each, Valid=1, Fault=00.
- RUN, fetch 0x6 then 0x200 with DEPTH=128 -> first returns 0x20110001 with Fault=01; second returns 0x00000000 with Fault=10, Valid=1.
- Fetch 0x4, hold Stall for 3 cycles while Address changes -> Instruction stays 0x20110001. Assert Flush together with Stall -> next edge Valid=0, Instruction=0x00000000.
- RUN, LoadEn=1 at 0x0 with data 0xFFFFFFFF -> LoadErr=1; a later fetch of 0x0 still returns 0x20100001.
- Mid-load Reset after 2 writes, then LoadDone -> LoadCount=0 after reset; fetch of 0x4 returns the word written before reset.
